// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for the single-clock FIFO.
// The producer/consumer side uses the master modport and the FIFO uses the slave modport.
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             rd_en;
  logic [WIDTH-1:0] rdata;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, wdata, rd_en,
    input  rdata, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wdata, rd_en,
    output rdata, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO.
// It provides occupancy count, almost-full/empty thresholds, and overflow/underflow pulses.
// Two read modes are available: registered read (FWFT=0) and first-word-fall-through (FWFT=1).
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input logic              clk,
  input logic              res,
  sync_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and >= 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL out of range 1..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q, count_next;
  logic             full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
  logic             wr_ok, rd_ok;

  // Acceptance is decided only from the flags registered before the edge.
  assign wr_ok = bus.wr_en & ~full_q;
  assign rd_ok = bus.rd_en & ~empty_q;

  // Occupancy after this edge; a simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next = count_q;
    if (wr_ok && !rd_ok)      count_next = count_q + 1'b1;
    else if (rd_ok && !wr_ok) count_next = count_q - 1'b1;
  end

  // Storage array; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= bus.wdata;
  end

  // Pointers, count, registered status flags and error pulses.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_next;
      full_q  <= (count_next == DEPTH_C);
      empty_q <= (count_next == '0);
      af_q    <= (count_next >= AF_C);
      ae_q    <= (count_next <= AE_C);
      ovf_q   <= bus.wr_en & full_q;
      udf_q   <= bus.rd_en & empty_q;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented combinationally; it is meaningless while empty.
    assign bus.rdata    = mem[rd_ptr];
    assign bus.rd_valid = 1'b0;
  end else begin : g_std
    logic [WIDTH-1:0] rdata_q;
    logic             rd_valid_q;

    // Registered read: the popped word appears one clock after the accepted read.
    always_ff @(posedge clk or negedge res) begin
      if (!res) begin
        rdata_q    <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_ok;
        if (rd_ok) rdata_q <= mem[rd_ptr];
      end
    end

    assign bus.rdata    = rdata_q;
    assign bus.rd_valid = rd_valid_q;
  end

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised successor to the dual-clock FIFO, used where producer and consumer share one clock domain. Width and depth are configurable. It adds an occupancy count, almost-full and almost-empty thresholds, a read-valid strobe and a selectable first-word-fall-through (FWFT) read mode. It keeps the full/overflow and empty/underflow status set that the existing write/read BFMs and monitors already drive and sample.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 16, number of entries; power of two, >= 2
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1

Ports:
clk  in  1  single clock; all logic on its rising edge
res  in  1  asynchronous, active-low reset
wr_en  in  1  write request
wdata  in  WIDTH  write data
rd_en  in  1  read request
rdata  out  WIDTH  read data
rd_valid  out  1  rdata carries a newly popped word (standard mode only)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: write rejected
underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset (res low, asynchronous):
  - wr_ptr, rd_ptr and count = 0.
  - empty = 1; almost_empty = 1 (AE_LEVEL >= 0).
  - full, almost_full, overflow, underflow, rd_valid = 0; rdata = 0.
  - Memory contents are not reset.
  - Release is sampled on the next clk edge.
  - Reset mid-operation discards all stored data; no pulse survives reset.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. count is the separate source of the full/empty decode.
- Write accepted iff wr_en && !full at the edge: mem[wr_ptr] <= wdata, wr_ptr++.
- Read accepted iff rd_en && !empty at the edge: rd_ptr++.
- Acceptance uses the pre-edge full/empty only:
  - Write while full is rejected even if a read is accepted in the same cycle.
  - Read while empty is rejected even if a write is accepted in the same cycle.
- count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Status outputs (full, empty, almost_full, almost_empty) are registered and reflect the updated count in the cycle after the edge.
- overflow: registered, high exactly one cycle after an edge where wr_en && full. The write is dropped; pointers and count are unaffected by it.
- underflow: registered, high exactly one cycle after an edge where rd_en && empty. rdata holds; rd_valid stays 0.
- Standard mode (FWFT=0):
  - On an accepted read, rdata <= mem[rd_ptr] and rd_valid = 1 for that one following cycle.
  - rdata holds its last value otherwise.
  - Read latency is 1 clock.
- FWFT mode (FWFT=1):
  - rdata = mem[rd_ptr] whenever empty = 0; the head word is visible before rd_en.
  - An accepted read advances to the next word, visible after the edge.
  - rdata is don't-care while empty = 1.
  - rd_valid is tied 0.
  - Write-to-visible latency is 1 clock (empty deasserts the cycle after the first write).
- Wrap-around: after DEPTH writes and DEPTH reads, both pointers return to 0 with no data corruption or flag glitch.
- Elaboration error if DEPTH is not a power of two, or AF_LEVEL/AE_LEVEL are out of range.

Test Plan:
1. Reset then idle, DEPTH=16 -> empty=1, almost_empty=1, full=0, count=0, rdata=0, no overflow/underflow pulse.
2. Write 0x00..0x0F on 16 consecutive cycles, then read 16, FWFT=0 -> full=1 after the 16th write. almost_full rises after the 12th write. Reads return 0x00..0x0F in order, each with rd_valid 1 cycle after rd_en. empty=1 at the end.
3. Full FIFO, wr_en=1 with wdata=0xAA for one cycle -> overflow pulses one cycle, count stays 16, 0xAA is never read back. Then rd_en and wr_en together -> the read succeeds, the write is rejected, overflow pulses again, count=15.
4. Empty FIFO, rd_en=1 -> underflow pulses one cycle, count=0, rd_valid=0. Then write 0x55 and read in the same cycle -> the read is rejected, underflow pulses, count=1.
5. FWFT=1: write 0x3C -> the next cycle empty=0 and rdata=0x3C with no rd_en. Pulse rd_en -> empty=1 and count=0.
6. Stream 40 words with wr_en and rd_en continuously high at half occupancy, then assert res low mid-stream -> data order is preserved across pointer wrap. Reset immediately forces count=0 and empty=1, and later reads return only post-reset writes.
